// File: rtl/mcu_bus_ctrl.sv
// mcu_bus_ctrl: MCU parallel-bus slave decoding busclk beats into command/write strobes
module mcu_bus_ctrl #(
    parameter int BUS_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] DEVICE_ID = 8'hAE
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  busclk,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic                  command_data,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic                  bus_oe,
    output logic                  cmd_strobe,
    output logic [BUS_WIDTH-1:0]  cmd_code,
    output logic                  wr_strobe,
    output logic [BUS_WIDTH-1:0]  wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  autoinc,
    output logic                  busy
);
    localparam int ADDR_BEATS = ADDR_WIDTH / BUS_WIDTH;
    localparam int CW = $clog2(ADDR_BEATS + 1);
    localparam logic [BUS_WIDTH-1:0] GET_ID = BUS_WIDTH'(1);
    localparam logic [BUS_WIDTH-1:0] SET_ADDRESS = BUS_WIDTH'(2);
    localparam logic [BUS_WIDTH-1:0] SET_AUTOINC = BUS_WIDTH'(3);
    typedef enum logic [1:0] {IDLE, ADDR, AUTOINC, ID_READ} state_t;
    state_t state, state_n;
    logic [2:0] sync;
    logic [ADDR_WIDTH-1:0] shadow, shadow_n, address_n, wr_addr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BUS_WIDTH-1:0] bus_out_n, cmd_code_n, wr_data_n;
    logic bus_oe_n, cmd_strobe_n, wr_strobe_n, autoinc_n;
    logic beat, is_cmd, is_dat, last, get_id, set_addr, fwd, ld_addr, set_ai, wr;
    assign beat = sync[2:1] == 2'b01;
    // A command beat outside ID_READ is decoded as from IDLE, which also aborts ADDR/AUTOINC
    assign is_cmd = beat && !command_data && state != ID_READ;
    assign is_dat = beat && command_data && state != ID_READ;
    assign last = cnt == CW'(ADDR_BEATS - 1);
    assign get_id = is_cmd && bus_in == GET_ID;
    assign set_addr = is_cmd && bus_in == SET_ADDRESS;
    assign fwd = is_cmd && bus_in != GET_ID && bus_in != SET_ADDRESS && bus_in != SET_AUTOINC;
    assign ld_addr = is_dat && state == ADDR && last;
    assign set_ai = is_dat && state == AUTOINC;
    assign wr = is_dat && state == IDLE;
    assign busy = state != IDLE;
    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (beat && state == ID_READ) state_n = IDLE;
        else if (is_cmd) state_n = get_id ? ID_READ : set_addr ? ADDR : bus_in == SET_AUTOINC ? AUTOINC : IDLE;
        else if (ld_addr || set_ai) state_n = IDLE;
    end
    always_comb begin
        shadow_n = set_addr ? '0 : (is_dat && state == ADDR) ? ((shadow << BUS_WIDTH) | ADDR_WIDTH'(bus_in)) : shadow;
        cnt_n = set_addr ? '0 : (is_dat && state == ADDR) ? cnt + CW'(1) : cnt;
        cmd_strobe_n = fwd || ld_addr || set_ai;
        cmd_code_n = fwd ? bus_in : ld_addr ? SET_ADDRESS : set_ai ? SET_AUTOINC : cmd_code;
        wr_strobe_n = wr;
        wr_data_n = wr ? bus_in : wr_data;
        wr_addr_n = wr ? address : wr_addr;
        address_n = ld_addr ? shadow_n : (wr && autoinc) ? address + ADDR_WIDTH'(1) : address;
        autoinc_n = set_ai ? |bus_in : autoinc;
        bus_out_n = get_id ? DEVICE_ID : bus_out;
        bus_oe_n = get_id ? 1'b1 : (beat && state == ID_READ) ? 1'b0 : bus_oe;
    end
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync <= 3'b111;
            shadow <= '0;
            cnt <= '0;
            bus_out <= '0;
            bus_oe <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd_code <= '0;
            wr_strobe <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
            address <= '0;
            autoinc <= 1'b1;
        end else begin
            sync <= {sync[1:0], busclk};
            shadow <= shadow_n;
            cnt <= cnt_n;
            bus_out <= bus_out_n;
            bus_oe <= bus_oe_n;
            cmd_strobe <= cmd_strobe_n;
            cmd_code <= cmd_code_n;
            wr_strobe <= wr_strobe_n;
            wr_data <= wr_data_n;
            wr_addr <= wr_addr_n;
            address <= address_n;
            autoinc <= autoinc_n;
        end
    end
endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// tb_mcu_bus_ctrl: random and directed beats checked against a transaction-level model
module tb_mcu_bus_ctrl;
    logic sysclk = 0, reset = 1, busclk = 0, command_data = 0;
    logic [7:0] bus_in = 0;
    logic [7:0] bus_out, cmd_code, wr_data;
    logic bus_oe, cmd_strobe, wr_strobe, autoinc, busy;
    logic [31:0] wr_addr, address;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] got_cmd[$], exp_cmd[$];
    logic [39:0] got_wr[$], exp_wr[$];
    logic [31:0] m_addr;
    logic [7:0] m_bout;
    logic m_ai, m_oe;
    logic [7:0] m_sh[$];
    string m_mode;

    mcu_bus_ctrl dut (
        .sysclk(sysclk), .reset(reset), .busclk(busclk), .bus_in(bus_in),
        .command_data(command_data), .bus_out(bus_out), .bus_oe(bus_oe),
        .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .wr_strobe(wr_strobe),
        .wr_data(wr_data), .wr_addr(wr_addr), .address(address),
        .autoinc(autoinc), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (cmd_strobe) got_cmd.push_back(cmd_code);
        if (wr_strobe) got_wr.push_back({wr_addr, wr_data});
        if (cmd_strobe && wr_strobe) check("strobe_excl", 1, 0);
    end

    task automatic model_reset();
        m_addr = 0; m_ai = 1; m_oe = 0; m_bout = 0; m_mode = ""; m_sh.delete();
    endtask

    task automatic model(input bit cd, input logic [7:0] d);
        if (m_mode == "id") begin
            m_oe = 0; m_mode = "";
        end else if (!cd) begin
            m_mode = "";
            case (d)
                8'h01: begin m_mode = "id"; m_oe = 1; m_bout = 8'hAE; end
                8'h02: begin m_mode = "addr"; m_sh.delete(); end
                8'h03: m_mode = "ai";
                default: exp_cmd.push_back(d);
            endcase
        end else if (m_mode == "addr") begin
            m_sh.push_back(d);
            if (m_sh.size() == 4) begin
                m_addr = {m_sh[0], m_sh[1], m_sh[2], m_sh[3]};
                exp_cmd.push_back(8'h02);
                m_mode = "";
            end
        end else if (m_mode == "ai") begin
            m_ai = d != 0; exp_cmd.push_back(8'h03); m_mode = "";
        end else begin
            exp_wr.push_back({m_addr, d});
            if (m_ai) m_addr = m_addr + 1;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) check({tag, "_cmd"}, got_cmd[i], exp_cmd[i]);
        check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) check({tag, "_wr"}, got_wr[i], exp_wr[i]);
        check({tag, "_addr"}, address, m_addr);
        check({tag, "_ai"}, autoinc, m_ai);
        check({tag, "_oe"}, bus_oe, m_oe);
        check({tag, "_busy"}, busy, m_mode != "");
        if (m_oe) check({tag, "_bout"}, bus_out, m_bout);
        got_cmd.delete(); exp_cmd.delete(); got_wr.delete(); exp_wr.delete();
    endtask

    task automatic send(input bit cd, input logic [7:0] d, input string tag);
        @(negedge sysclk);
        bus_in = d; command_data = cd;
        model(cd, d);
        @(negedge sysclk) busclk = 1;
        repeat (3) @(negedge sysclk);
        busclk = 0;
        repeat (3) @(negedge sysclk);
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sysclk);
        busclk = 0; reset = 1;
        repeat (3) @(negedge sysclk);
        got_cmd.delete(); got_wr.delete();
        reset = 0;
        model_reset();
        repeat (4) @(negedge sysclk);
        compare(tag);
    endtask

    initial begin
        int r;
        logic [7:0] d;
        do_reset("rst");
        check("rst_cmd_code", cmd_code, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_strobes", {cmd_strobe, wr_strobe}, 0);
        send(0, 8'h01, "getid");
        check("getid_bout", bus_out, 8'hAE);
        send(1, 8'h77, "idrd");
        send(0, 8'h02, "sa"); send(1, 8'h12, "sa1"); send(1, 8'h34, "sa2"); send(1, 8'h56, "sa3");
        send(1, 8'h78, "sa4");
        check("sa_value", address, 32'h12345678);
        send(0, 8'h02, "wa"); send(1, 8'hFF, "wa1"); send(1, 8'hFF, "wa2"); send(1, 8'hFF, "wa3");
        send(1, 8'hFE, "wa4");
        send(1, 8'hA1, "wrap1"); send(1, 8'hA2, "wrap2"); send(1, 8'hA3, "wrap3");
        check("wrap_value", address, 32'h1);
        send(0, 8'h03, "ai0"); send(1, 8'h00, "ai0d");
        send(1, 8'h11, "noinc1"); send(1, 8'h22, "noinc2");
        check("noinc_value", address, 32'h1);
        send(0, 8'h03, "ai1"); send(1, 8'h80, "ai1d");
        check("ai_on", autoinc, 1);
        send(0, 8'h02, "ab"); send(1, 8'hDE, "ab1"); send(1, 8'hAD, "ab2"); send(0, 8'h55, "ab3");
        check("ab_keep", address, 32'h1);
        send(0, 8'h02, "rs"); send(1, 8'hCA, "rs1"); send(1, 8'hFE, "rs2");
        do_reset("rs_rst");
        send(1, 8'h5A, "rs_wr");
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if (r < 4) do_reset("r_rst");
            else if (r < 12) send(0, 8'h01, "r_id");
            else if (r < 22) send(0, 8'h02, "r_sa");
            else if (r < 30) send(0, 8'h03, "r_ai");
            else if (r < 40) send(0, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(4, 255)), "r_cmd");
            else send(1, d, "r_dat");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
